// File: rtl/keypad_emulator_if.sv
// Request/response and row/column bundle between a press sequencer, a keypad scanner
// and keypad_emulator.
interface keypad_emulator_if;
    logic       press_req;
    logic [3:0] press_key;
    logic [3:0] keypadRow;
    logic [3:0] keypadCol;
    logic       busy;
    logic       press_done;
    logic [7:0] scan_hits;

    modport master (
        output press_req, press_key, keypadRow,
        input  keypadCol, busy, press_done, scan_hits
    );

    modport slave (
        input  press_req, press_key, keypadRow,
        output keypadCol, busy, press_done, scan_hits
    );
endinterface

// File: rtl/keypad_emulator.sv
// Emulates a single 4x4 keypad key closure answering the scanner's row strobes.
// Optional contact bounce around the hold phase is enabled by defining KEYPAD_BOUNCE_EN.
module keypad_emulator #(
    parameter int unsigned HOLD_CYCLES   = 32'd1000000,
    parameter int unsigned BOUNCE_CYCLES = 16'd64
) (
    input  logic             clk,
    input  logic             rst,
    keypad_emulator_if.slave kp
);

`ifdef KEYPAD_BOUNCE_EN
    typedef enum logic [2:0] {StIdle, StBncPress, StHold, StBncRelease, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StHold, StDone} state_e;
`endif

    // Terminal counts; a zero hold length behaves as a single cycle.
    localparam logic [31:0] HoldLast = (HOLD_CYCLES == 0) ? 32'd0 : 32'(HOLD_CYCLES - 1);

    if (BOUNCE_CYCLES > 32'd65535) begin : g_bounce_range
        $error("BOUNCE_CYCLES does not fit the 16-bit bounce counter");
    end

    state_e      state_q, state_d;
    logic [3:0]  key_q, key_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]  hits_q, hits_d;
    logic [3:0]  col_q, col_d;
    logic        accept;
    logic        sw_closed;
    logic [1:0]  row_sel;
    logic [1:0]  col_sel;

`ifdef KEYPAD_BOUNCE_EN
    localparam logic [15:0] BncLast = (BOUNCE_CYCLES == 0) ? 16'd0 : 16'(BOUNCE_CYCLES - 1);

    logic [15:0] bnc_cnt_q, bnc_cnt_d;
`endif

    assign accept  = (state_q == StIdle) && kp.press_req;
    // (15 - k) on four bits is simply ~k.
    assign row_sel = ~key_q[3:2];
    assign col_sel = ~key_q[1:0];

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (kp.press_req) begin
`ifdef KEYPAD_BOUNCE_EN
                    state_d = StBncPress;
`else
                    state_d = StHold;
`endif
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            StBncPress: begin
                if (bnc_cnt_q == BncLast) begin
                    state_d = StHold;
                end
            end
`endif
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
`ifdef KEYPAD_BOUNCE_EN
                    state_d = StBncRelease;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            StBncRelease: begin
                if (bnc_cnt_q == BncLast) begin
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        kp.busy       = (state_q != StIdle);
        kp.press_done = (state_q == StDone);
        sw_closed     = 1'b0;
        unique case (state_q)
            StHold: sw_closed = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
            // Press bounce starts open; release bounce is phased so its last cycle is open.
            StBncPress:   sw_closed = bnc_cnt_q[0];
            StBncRelease: sw_closed = bnc_cnt_q[0] ^ BncLast[0];
`endif
            default: sw_closed = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        key_d      = key_q;
        hold_cnt_d = hold_cnt_q;
        hits_d     = hits_q;
        if (accept) begin
            key_d      = kp.press_key;
            hold_cnt_d = '0;
            hits_d     = '0;
        end else if (state_q == StHold) begin
            hold_cnt_d = hold_cnt_q + 32'd1;
            if (!kp.keypadRow[row_sel] && (hits_q != 8'hFF)) begin
                hits_d = hits_q + 8'd1;
            end
        end

        col_d = 4'hF;
        if (sw_closed) begin
            col_d[col_sel] = kp.keypadRow[row_sel];
        end
    end

`ifdef KEYPAD_BOUNCE_EN
    always_comb begin
        bnc_cnt_d = '0;
        if (((state_q == StBncPress) || (state_q == StBncRelease)) && (bnc_cnt_q != BncLast)) begin
            bnc_cnt_d = bnc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bnc_cnt_q <= '0;
        end else begin
            bnc_cnt_q <= bnc_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q      <= '0;
            hold_cnt_q <= '0;
            hits_q     <= '0;
            col_q      <= 4'hF;
        end else begin
            key_q      <= key_d;
            hold_cnt_q <= hold_cnt_d;
            hits_q     <= hits_d;
            col_q      <= col_d;
        end
    end

    assign kp.keypadCol = col_q;
    assign kp.scan_hits = hits_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: directed and randomized presses compared
// against a per-press behavioural model of switch state, column response and hit count.
module tb_keypad_emulator;

    localparam int unsigned Hold    = 8;
    localparam int unsigned Bnc     = 4;
    localparam int unsigned HoldSat = 300;
`ifdef KEYPAD_BOUNCE_EN
    localparam int unsigned PreLen  = (Bnc == 0) ? 1 : Bnc;
`else
    localparam int unsigned PreLen  = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_emulator_if kif ();
    keypad_emulator_if kif_sat ();

    keypad_emulator #(.HOLD_CYCLES(Hold), .BOUNCE_CYCLES(Bnc)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    keypad_emulator #(.HOLD_CYCLES(HoldSat), .BOUNCE_CYCLES(Bnc)) dut_sat (
        .clk (clk),
        .rst (rst),
        .kp  (kif_sat)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] row_for(input int mode, input int i, input logic [3:0] base);
        logic [3:0] one;
        one = 4'b0001;
        case (mode)
            0:       return base;
            1:       return ~(one << (i % 4));
            default: return 4'($urandom);
        endcase
    endfunction

    // Column lines a closed/open key k presents for a given row pattern.
    function automatic logic [3:0] exp_col(input bit closed, input logic [3:0] row, input int k);
        logic [3:0] v;
        int r, c;
        v = 4'hF;
        r = (15 - k) >> 2;
        c = (15 - k) & 3;
        if (closed) v[c] = row[r];
        return v;
    endfunction

    // One complete press; spurious requests with random keys are thrown in when asked.
    task automatic run_press(input int k, input int mode, input logic [3:0] base, input bit spurious);
        bit sw[$];
        bit in_hold[$];
        bit prev_closed;
        logic [3:0] row, prev_row;
        int hits, len, h, r;
        h = (Hold == 0) ? 1 : Hold;
        r = (15 - k) >> 2;
`ifdef KEYPAD_BOUNCE_EN
        if (Bnc == 0) begin sw.push_back(1'b0); in_hold.push_back(1'b0); end
        for (int i = 0; i < int'(Bnc); i++) begin sw.push_back(i % 2 == 1); in_hold.push_back(1'b0); end
`endif
        for (int i = 0; i < h; i++) begin sw.push_back(1'b1); in_hold.push_back(1'b1); end
`ifdef KEYPAD_BOUNCE_EN
        if (Bnc == 0) begin sw.push_back(1'b0); in_hold.push_back(1'b0); end
        for (int i = 0; i < int'(Bnc); i++) begin
            sw.push_back(((int'(Bnc) - 1 - i) % 2) == 1);
            in_hold.push_back(1'b0);
        end
`endif
        sw.push_back(1'b0);
        in_hold.push_back(1'b0);
        len = sw.size();

        row = row_for(mode, 0, base);
        kif.press_req = 1'b1;
        kif.press_key = 4'(k);
        kif.keypadRow = row;
        prev_closed = 1'b0;
        prev_row = row;
        hits = 0;
        for (int i = 0; i < len; i++) begin
            step();
            check($sformatf("busy k=%0d ph=%0d", k, i), kif.busy, 1);
            check($sformatf("done k=%0d ph=%0d", k, i), kif.press_done, (i == len - 1) ? 1 : 0);
            check($sformatf("col k=%0d ph=%0d", k, i), kif.keypadCol, exp_col(prev_closed, prev_row, k));
            kif.press_req = spurious ? 1'($urandom) : 1'b0;
            kif.press_key = 4'($urandom);
            row = row_for(mode, i + 1, base);
            kif.keypadRow = row;
            prev_closed = sw[i];
            prev_row = row;
            if (in_hold[i] && !row[r]) hits++;
        end
        step();
        check($sformatf("idle busy k=%0d", k), kif.busy, 0);
        check($sformatf("idle done k=%0d", k), kif.press_done, 0);
        check($sformatf("idle col k=%0d", k), kif.keypadCol, 4'hF);
        check($sformatf("hits k=%0d", k), kif.scan_hits, (hits > 255) ? 255 : hits);
        kif.press_req = 1'b0;
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        kif.press_req = 1'b0;
        kif.press_key = 4'h0;
        kif.keypadRow = 4'hF;
        kif_sat.press_req = 1'b0;
        kif_sat.press_key = 4'h0;
        kif_sat.keypadRow = 4'hF;
        step();
        check("rst col", kif.keypadCol, 4'hF);
        check("rst busy", kif.busy, 0);
        check("rst done", kif.press_done, 0);
        check("rst hits", kif.scan_hits, 0);
        rst = 1'b1;
        step();

        // Idle responder ignores row strobes.
        for (int i = 0; i < 4; i++) begin
            kif.keypadRow = 4'($urandom);
            step();
            check("idle col", kif.keypadCol, 4'hF);
            check("idle busy", kif.busy, 0);
        end

        run_press(12, 0, 4'b1110, 1'b0);
        run_press(5, 1, 4'hF, 1'b0);
        run_press(0, 2, 4'hF, 1'b1);
        run_press(15, 0, 4'b1110, 1'b0);
        run_press(0, 0, 4'b0111, 1'b1);
        for (int n = 0; n < 20; n++) begin
            run_press(int'($urandom_range(15, 0)), int'($urandom_range(2, 0)), 4'($urandom),
                      1'($urandom));
        end
        step();

        // Reset asserted mid-hold releases the columns without a clock edge.
        kif.press_req = 1'b1;
        kif.press_key = 4'd15;
        kif.keypadRow = 4'b1110;
        step();
        kif.press_req = 1'b0;
        for (int i = 0; i < int'(PreLen) + 1; i++) step();
        check("mid hold col", kif.keypadCol, 4'b1110);
        #2;
        rst = 1'b0;
        #1;
        check("async rst col", kif.keypadCol, 4'hF);
        check("async rst busy", kif.busy, 0);
        check("async rst done", kif.press_done, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < int'(Hold + 2 * PreLen) + 4; i++) begin
            step();
            check("post rst done", kif.press_done, 0);
            check("post rst busy", kif.busy, 0);
        end

        // Hit counter saturation on a long hold.
        kif_sat.press_req = 1'b1;
        kif_sat.press_key = 4'd0;
        kif_sat.keypadRow = 4'b0111;
        step();
        kif_sat.press_req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            step();
            if (kif_sat.press_done) seen = 1'b1;
        end
        check("sat done seen", seen, 1);
        step();
        check("sat hits", kif_sat.scan_hits, 8'd255);
        check("sat busy", kif_sat.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Responder side of the 4x4 keypad row-drive/column-sense interface: watches the active-low row strobes driven by the keypad scanner and drives the active-low column lines as if a physical key were pressed.
- A press is requested over a simple req/busy/done handshake, so a self-test sequencer or a bench can inject hits without a physical keypad.
- Sits between the keypad scanner's keypadRow output and its keypadCol input.

Parameters:
- HOLD_CYCLES, 32'd1000000, clk cycles the key stays closed (0 treated as 1)
- BOUNCE_CYCLES, 16'd64, length of each contact-bounce window (used only with KEYPAD_BOUNCE_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- press_req  in  1  start a press; sampled only in IDLE
- press_key  in  4  key value 0..15, same encoding as the mole position
- keypadRow  in  4  active-low row strobes from the scanner
- keypadCol  out  4  active-low column lines to the scanner
- busy  out  1  press in progress
- press_done  out  1  one-cycle pulse at end of press
- scan_hits  out  8  count of cycles the pressed key's row was strobed during HOLD; saturates at 255

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-low.
- Reset values: keypadCol=4'b1111, busy=0, press_done=0, scan_hits=0, FSM=IDLE.
- Reset mid-press aborts immediately: columns release asynchronously and no press_done is issued.
- Key map for a latched key k:
  - row bit r=(15-k)>>2, column bit c=(15-k)&3.
  - Examples: k=15 -> row 4'b1110, col 4'b1110; k=12 -> row 4'b1110, col 4'b0111; k=0 -> row 4'b0111, col 4'b0111.
- Column drive:
  - Registered, 1-cycle latency from keypadRow.
  - When the switch is closed: keypadCol[c] = keypadRow[r]; all other column bits = 1.
  - When the switch is open: keypadCol = 4'b1111.
  - keypadRow=4'b1111 or a row pattern that does not strobe row r -> columns 4'b1111.
  - Multiple low row bits are legal; only bit r matters.
- States: IDLE, BNC_PRESS, HOLD, BNC_RELEASE, DONE.
  - IDLE:
    - On press_req=1: latch press_key, clear the hold counter and scan_hits.
    - Go to BNC_PRESS (macro defined) or HOLD (macro undefined).
    - busy rises the cycle after press_req is sampled.
  - BNC_PRESS: switch toggles every clk for BOUNCE_CYCLES cycles, then goes to HOLD.
  - HOLD:
    - Switch closed; the counter increments each cycle.
    - scan_hits increments each cycle keypadRow[r]=0, saturating at 255.
    - After HOLD_CYCLES cycles, go to BNC_RELEASE (macro defined) or DONE (macro undefined).
  - BNC_RELEASE: switch toggles every clk for BOUNCE_CYCLES cycles, ending open; then goes to DONE.
  - DONE:
    - Switch open; press_done=1 for exactly this one cycle; busy=0 from the next cycle.
    - Next state is IDLE.
    - scan_hits holds its value until the next accepted request.
- Handshake rules:
  - press_req while busy or in DONE is ignored; no queuing.
  - press_key is not re-sampled mid-press.
  - A request present in the cycle after DONE is accepted normally.
- Counter widths: hold counter 32 bits, bounce counter 16 bits.
  - Terminal compare is at the parameter value minus 1.
  - BOUNCE_CYCLES=0 makes the bounce states last one cycle with the switch open.

Optional Feature:
- KEYPAD_BOUNCE_EN:
  - Defined: the BNC_PRESS and BNC_RELEASE states exist and the switch toggles each clk inside them, to stress scanner debounce.
  - Undefined: the bounce states and the bounce counter are not compiled; the FSM goes IDLE -> HOLD -> DONE; BOUNCE_CYCLES is unused.

Test Plan (HOLD_CYCLES=8, BOUNCE_CYCLES=4 unless stated):
- Reset check: assert rst=0 mid-HOLD with k=15 and keypadRow=4'b1110 -> keypadCol=4'b1111, busy=0, press_done=0 immediately, with no clock edge needed.
- Basic press, macro undefined: press_key=12, press_req for 1 cycle, keypadRow held at 4'b1110.
  - keypadCol=4'b0111 for 8 cycles, delayed 1 cycle from the row.
  - press_done pulses once; scan_hits=8; busy high for 9 cycles.
- Row scan: k=5 (row 4'b1011, col bit 2) with keypadRow rotating 1110->1101->1011->0111 each cycle -> keypadCol=4'b1011 only in the cycle after row 4'b1011; scan_hits=2.
- Ignored request: pulse press_req with press_key=3 while busy with k=0 -> the press still completes as k=0, with a single press_done.
- Bounce, macro defined: k=15, keypadRow=4'b1110 -> keypadCol[0] toggles for 4 cycles, then is low for 8 cycles, then toggles for 4 cycles ending high; press_done follows.
- Saturation: HOLD_CYCLES=300, keypadRow=4'b0111, k=0 -> scan_hits=255.
